// File: rtl/game_ctrl_param.sv
// -----------------------------------------------------------------------------
// game_ctrl_param
//
// Round controller for the two-player factorization game (second generation).
// Runs the round flow READY -> QUESTION/INPUT -> result hold -> next round.
// Both players' HP are kept here, along with a per-question wrong-answer count
// and a played-rounds counter. Every result is shown for a fixed hold time
// before the flow moves on.
//
// Optional feature (macro GAME_TIMEOUT_EN):
//   When defined, an answer timer runs while the game is in QUESTION or INPUT.
//   It is cleared when READY moves to QUESTION and is frozen while the game is
//   in WRONG. When it reaches CLK_HZ*TIMEOUT_SEC-1, the controller forces OUCH.
//   A judge-driven transition on the same cycle still wins.
//   When the macro is not defined there is no answer timer and no time limit.
//
// Parameters:
//   CLK_HZ      clock frequency in Hz
//   HOLD_SEC    result hold time in seconds (HOLD_CYC = CLK_HZ*HOLD_SEC)
//   HP_INIT     starting HP per player (>= 1)
//   HP_W        HP register width (must hold HP_INIT)
//   WRONG_MAX   wrong answers per question before an automatic OUCH (>= 1)
//   ROUND_W     round counter width
//   TIMEOUT_SEC answer time limit in seconds (used only with GAME_TIMEOUT_EN)
//
// Ports:
//   CLK         system clock
//   RST         asynchronous, active-high reset
//   START_OK    level: both players pressed start
//   QUE_READY   level: the input module has stored a question
//   QUE_TOGGLE  one-cycle pulse: switch between QUESTION and INPUT
//   JUDG        judge result: 00 none, 01 self correct,
//               10 opponent correct, 11 both correct
//   WRONG       one-cycle pulse: self answered incorrectly
//   STATE       current state code (READY=2 QUESTION=3 INPUT=4 DRAW=6
//               WRONG=7 GOOD=8 OUCH=9 WIN=10 LOSE=11)
//   HP_SELF     own HP
//   HP_OPP      opponent HP
//   ROUND       rounds played since the last game start (saturating)
//   HOLD_BUSY   high while STATE is a hold state
//
// Input protocol: there is no valid/ready handshake. START_OK and QUE_READY
// are levels and are qualified by the current state. QUE_TOGGLE and WRONG are
// single-cycle pulses, consumed only in the state that reacts to them. JUDG is
// sampled every cycle and is ignored in READY and in all hold states.
//
// All outputs are registered (Moore). An input sampled at edge t shows up on
// STATE right after edge t. STATE doubles as the debug view of the FSM.
// -----------------------------------------------------------------------------
module game_ctrl_param #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int HOLD_SEC    = 1,
  parameter int HP_INIT     = 3,
  parameter int HP_W        = 2,
  parameter int WRONG_MAX   = 3,
  parameter int ROUND_W     = 4,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START_OK,
  input  logic               QUE_READY,
  input  logic               QUE_TOGGLE,
  input  logic [1:0]         JUDG,
  input  logic               WRONG,
  output logic [3:0]         STATE,
  output logic [HP_W-1:0]    HP_SELF,
  output logic [HP_W-1:0]    HP_OPP,
  output logic [ROUND_W-1:0] ROUND,
  output logic               HOLD_BUSY
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int HOLD_CYC = CLK_HZ * HOLD_SEC;
  localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int WCNT_W   = (WRONG_MAX > 1) ? $clog2(WRONG_MAX) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(WRONG_MAX - 1);
  localparam logic [HP_W-1:0]    HP_START  = HP_W'(HP_INIT);
  localparam logic [ROUND_W-1:0] ROUND_MAX = {ROUND_W{1'b1}};

  // Elaboration-time guard against parameter sets the datapath cannot hold.
  if (HP_INIT < 1 || HP_INIT > (2 ** HP_W) - 1 || WRONG_MAX < 1 ||
      HOLD_CYC < 1 || CLK_HZ * TIMEOUT_SEC < 1) begin : g_bad_params
    $error("game_ctrl_param: invalid parameter set");
  end

  // ---------------------------------------------------------------------------
  // State encoding: the values are the external STATE codes
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_READY    = 4'd2,
    S_QUESTION = 4'd3,
    S_INPUT    = 4'd4,
    S_DRAW     = 4'd6,
    S_WRONG    = 4'd7,
    S_GOOD     = 4'd8,
    S_OUCH     = 4'd9,
    S_WIN      = 4'd10,
    S_LOSE     = 4'd11
  } state_t;

  function automatic logic is_hold(input state_t s);
    case (s)
      S_DRAW, S_WRONG, S_GOOD, S_OUCH, S_WIN, S_LOSE: is_hold = 1'b1;
      default:                                        is_hold = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [HP_W-1:0]    hp_self_q,   hp_self_d;
  logic [HP_W-1:0]    hp_opp_q,    hp_opp_d;
  logic [ROUND_W-1:0] round_q,     round_d;
  logic [WCNT_W-1:0]  wrong_cnt_q, wrong_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic               hold_busy_q;

  logic hold_done;    // last cycle of the current hold state
  logic timeout_hit;  // answer time limit reached this cycle
  logic take_ouch;    // any path into OUCH (judge, wrong limit, timeout)
  logic round_inc;    // a round result is being entered

  assign hold_done = (hold_cnt_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // Optional answer timer
  // ---------------------------------------------------------------------------
`ifdef GAME_TIMEOUT_EN
  localparam int TMO_CYC = CLK_HZ * TIMEOUT_SEC;
  localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] ans_tmr_q, ans_tmr_d;

  // Counts only in QUESTION/INPUT, so it holds its value in WRONG. Reaching
  // TMO_LAST always forces an exit from QUESTION/INPUT, so it never wraps.
  always_comb begin
    ans_tmr_d = ans_tmr_q;
    if (state_q == S_READY && state_d == S_QUESTION) begin
      ans_tmr_d = '0;
    end else if ((state_q == S_QUESTION || state_q == S_INPUT) &&
                 ans_tmr_q != TMO_LAST) begin
      ans_tmr_d = ans_tmr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ans_tmr_q <= '0;
    end else begin
      ans_tmr_q <= ans_tmr_d;
    end
  end

  assign timeout_hit = (ans_tmr_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hp_self_d   = hp_self_q;
    hp_opp_d    = hp_opp_q;
    round_d     = round_q;
    wrong_cnt_d = wrong_cnt_q;
    hold_cnt_d  = '0;
    take_ouch   = 1'b0;
    round_inc   = 1'b0;

    case (state_q)
      S_READY: begin
        if (START_OK && QUE_READY) begin
          state_d     = S_QUESTION;
          wrong_cnt_d = '0;
        end
      end

      S_QUESTION: begin
        if (JUDG == 2'b10 || timeout_hit) begin
          take_ouch = 1'b1;
        end else if (QUE_TOGGLE && QUE_READY) begin
          state_d = S_INPUT;
        end
      end

      S_INPUT: begin
        // Judge results outrank everything, then the time limit, then the
        // player's own wrong answer, then a plain toggle back to QUESTION.
        if (JUDG == 2'b11) begin
          state_d   = S_DRAW;
          round_inc = 1'b1;
        end else if (JUDG == 2'b01) begin
          state_d   = S_GOOD;
          hp_opp_d  = (hp_opp_q != '0) ? hp_opp_q - 1'b1 : '0;
          round_inc = 1'b1;
        end else if (JUDG == 2'b10 || timeout_hit) begin
          take_ouch = 1'b1;
        end else if (WRONG) begin
          if (wrong_cnt_q == WCNT_LAST) begin
            take_ouch   = 1'b1;
            wrong_cnt_d = '0;
          end else begin
            state_d     = S_WRONG;
            wrong_cnt_d = wrong_cnt_q + 1'b1;
          end
        end else if (QUE_TOGGLE) begin
          state_d = S_QUESTION;
        end
      end

      S_WRONG: begin
        if (hold_done) begin
          state_d = S_INPUT;
        end
      end

      S_GOOD: begin
        // Uses the HP already decremented on entry.
        if (hold_done) begin
          state_d = (hp_opp_q == '0) ? S_WIN : S_READY;
        end
      end

      S_OUCH: begin
        if (hold_done) begin
          state_d = (hp_self_q == '0) ? S_LOSE : S_READY;
        end
      end

      S_DRAW: begin
        if (hold_done) begin
          state_d = S_READY;
        end
      end

      S_WIN, S_LOSE: begin
        // The game is over: restore both players' HP and restart the count.
        if (hold_done) begin
          state_d   = S_READY;
          hp_self_d = HP_START;
          hp_opp_d  = HP_START;
          round_d   = '0;
        end
      end

      default: begin
        state_d = S_READY;
      end
    endcase

    if (take_ouch) begin
      state_d   = S_OUCH;
      hp_self_d = (hp_self_q != '0) ? hp_self_q - 1'b1 : '0;
      round_inc = 1'b1;
    end

    if (round_inc && round_q != ROUND_MAX) begin
      round_d = round_q + 1'b1;
    end

    // The hold counter is zero outside hold states and on the expiry edge,
    // so every hold state starts counting from zero.
    if (is_hold(state_q) && !hold_done) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_READY;
      hp_self_q   <= HP_START;
      hp_opp_q    <= HP_START;
      round_q     <= '0;
      wrong_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hold_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_self_q   <= hp_self_d;
      hp_opp_q    <= hp_opp_d;
      round_q     <= round_d;
      wrong_cnt_q <= wrong_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_busy_q <= is_hold(state_d);
    end
  end

  assign STATE     = state_q;
  assign HP_SELF   = hp_self_q;
  assign HP_OPP    = hp_opp_q;
  assign ROUND     = round_q;
  assign HOLD_BUSY = hold_busy_q;

endmodule

// File: tb/tb_game_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_param
//
// Bench for game_ctrl_param with CLK_HZ=4, HOLD_SEC=1 (hold of 4 cycles),
// HP_INIT=2, WRONG_MAX=2 and TIMEOUT_SEC=2.
//
// A behavioural game model tracks the expected outputs. It uses integer codes
// and a countdown of the hold cycles that remain. After every clock edge the
// model's outputs go into exp_q, and the bench compares them with the DUT.
// Directed scenarios also check fixed expected values. After those, a
// randomized phase runs.
// -----------------------------------------------------------------------------
module tb_game_ctrl_param;

  localparam int CLK_HZ      = 4;
  localparam int HOLD_SEC    = 1;
  localparam int HP_INIT     = 2;
  localparam int HP_W        = 2;
  localparam int WRONG_MAX   = 2;
  localparam int ROUND_W     = 4;
  localparam int TIMEOUT_SEC = 2;

  localparam int HOLD_CYC  = CLK_HZ * HOLD_SEC;
  localparam int TMO_CYC   = CLK_HZ * TIMEOUT_SEC;
  localparam int ROUND_MAX = (1 << ROUND_W) - 1;
`ifdef GAME_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int ST_READY = 2, ST_QUESTION = 3, ST_INPUT = 4, ST_DRAW = 6;
  localparam int ST_WRONG = 7, ST_GOOD = 8, ST_OUCH = 9, ST_WIN = 10, ST_LOSE = 11;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_ok = 1'b0;
  logic               que_ready = 1'b0;
  logic               que_toggle = 1'b0;
  logic [1:0]         judg = 2'b00;
  logic               wrong = 1'b0;
  logic [3:0]         state;
  logic [HP_W-1:0]    hp_self;
  logic [HP_W-1:0]    hp_opp;
  logic [ROUND_W-1:0] round_cnt;
  logic               hold_busy;

  always #5 clk = ~clk;

  game_ctrl_param #(
    .CLK_HZ(CLK_HZ), .HOLD_SEC(HOLD_SEC), .HP_INIT(HP_INIT), .HP_W(HP_W),
    .WRONG_MAX(WRONG_MAX), .ROUND_W(ROUND_W), .TIMEOUT_SEC(TIMEOUT_SEC)
  ) dut (
    .CLK(clk), .RST(rst), .START_OK(start_ok), .QUE_READY(que_ready),
    .QUE_TOGGLE(que_toggle), .JUDG(judg), .WRONG(wrong), .STATE(state),
    .HP_SELF(hp_self), .HP_OPP(hp_opp), .ROUND(round_cnt), .HOLD_BUSY(hold_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  localparam int EW = 4 + HP_W + HP_W + ROUND_W + 1;
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_state, m_hp_s, m_hp_o, m_round, m_wrong, m_hold_left, m_timer;

  function automatic bit m_is_hold(input int s);
    return (s == ST_DRAW || s == ST_WRONG || s == ST_GOOD ||
            s == ST_OUCH || s == ST_WIN || s == ST_LOSE);
  endfunction

  task automatic m_reset();
    m_state = ST_READY; m_hp_s = HP_INIT; m_hp_o = HP_INIT;
    m_round = 0; m_wrong = 0; m_hold_left = 0; m_timer = 0;
  endtask

  task automatic m_enter_hold(input int s);
    m_state = s;
    m_hold_left = HOLD_CYC;
  endtask

  task automatic m_round_inc();
    if (m_round < ROUND_MAX) m_round++;
  endtask

  task automatic m_ouch();
    m_enter_hold(ST_OUCH);
    if (m_hp_s > 0) m_hp_s--;
    m_round_inc();
  endtask

  task automatic m_step();
    bit tmo;
    tmo = TMO_EN && (m_timer == TMO_CYC - 1);
    if (m_state == ST_READY) begin
      if (start_ok && que_ready) begin
        m_state = ST_QUESTION; m_wrong = 0; m_timer = 0;
      end
    end else if (m_state == ST_QUESTION) begin
      m_timer++;
      if (judg == 2'b10 || tmo) m_ouch();
      else if (que_toggle && que_ready) m_state = ST_INPUT;
    end else if (m_state == ST_INPUT) begin
      m_timer++;
      if (judg == 2'b11) begin
        m_enter_hold(ST_DRAW); m_round_inc();
      end else if (judg == 2'b01) begin
        m_enter_hold(ST_GOOD);
        if (m_hp_o > 0) m_hp_o--;
        m_round_inc();
      end else if (judg == 2'b10 || tmo) begin
        m_ouch();
      end else if (wrong) begin
        if (m_wrong == WRONG_MAX - 1) begin
          m_wrong = 0; m_ouch();
        end else begin
          m_wrong++; m_enter_hold(ST_WRONG);
        end
      end else if (que_toggle) begin
        m_state = ST_QUESTION;
      end
    end else begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        case (m_state)
          ST_WRONG: m_state = ST_INPUT;
          ST_GOOD:  if (m_hp_o == 0) m_enter_hold(ST_WIN); else m_state = ST_READY;
          ST_OUCH:  if (m_hp_s == 0) m_enter_hold(ST_LOSE); else m_state = ST_READY;
          ST_DRAW:  m_state = ST_READY;
          default: begin
            m_state = ST_READY; m_hp_s = HP_INIT; m_hp_o = HP_INIT; m_round = 0;
          end
        endcase
      end
    end
  endtask

  function automatic logic [EW-1:0] m_pack();
    return {4'(m_state), HP_W'(m_hp_s), HP_W'(m_hp_o), ROUND_W'(m_round),
            m_is_hold(m_state)};
  endfunction

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    chk("state",     int'(state),     int'(e[EW-1 -: 4]));
    chk("hp_self",   int'(hp_self),   int'(e[EW-5 -: HP_W]));
    chk("hp_opp",    int'(hp_opp),    int'(e[EW-5-HP_W -: HP_W]));
    chk("round",     int'(round_cnt), int'(e[ROUND_W:1]));
    chk("hold_busy", int'(hold_busy), int'(e[0]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock: the model steps on the same edge as the DUT, and outputs are
  // compared 1 time unit later. Inputs are changed only after this returns.
  task automatic cycle();
    @(posedge clk);
    m_step();
    exp_q.push_back(m_pack());
    #1;
    check_outputs();
  endtask

  // Reset asserted and checked between clock edges.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    m_reset();
    exp_q.push_back(m_pack());
    check_outputs();
    #1;
    rst = 1'b0;
  endtask

  task automatic begin_question();
    start_ok = 1'b1; que_ready = 1'b1;
    cycle();
    chk("enter_question", int'(state), ST_QUESTION);
    start_ok = 1'b0;
    que_toggle = 1'b1;
    cycle();
    chk("enter_input", int'(state), ST_INPUT);
    que_toggle = 1'b0;
  endtask

  task automatic hold_then(input string tag, input int hold_st, input int next_st);
    repeat (HOLD_CYC - 1) begin
      cycle();
      chk({tag, "_hold"}, int'(state), hold_st);
    end
    cycle();
    chk({tag, "_exit"}, int'(state), next_st);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    m_reset();
    #2;
    async_reset();
    chk("rst_state", int'(state), ST_READY);
    chk("rst_busy", int'(hold_busy), 0);

    // 1: one GOOD round
    begin_question();
    judg = 2'b01;
    cycle();
    judg = 2'b00;
    chk("t1_good", int'(state), ST_GOOD);
    chk("t1_hp_opp", int'(hp_opp), 1);
    chk("t1_round", int'(round_cnt), 1);
    chk("t1_busy", int'(hold_busy), 1);
    hold_then("t1", ST_GOOD, ST_READY);

    // 2: second GOOD ends the game with WIN, then everything restarts
    begin_question();
    judg = 2'b01;
    cycle();
    judg = 2'b00;
    chk("t2_hp_opp", int'(hp_opp), 0);
    hold_then("t2", ST_GOOD, ST_WIN);
    hold_then("t2_win", ST_WIN, ST_READY);
    chk("t2_hp_self", int'(hp_self), HP_INIT);
    chk("t2_hp_opp_rst", int'(hp_opp), HP_INIT);
    chk("t2_round", int'(round_cnt), 0);

    // 3: first WRONG holds, second WRONG gives OUCH
    begin_question();
    wrong = 1'b1;
    cycle();
    wrong = 1'b0;
    chk("t3_wrong", int'(state), ST_WRONG);
    hold_then("t3", ST_WRONG, ST_INPUT);
    wrong = 1'b1;
    cycle();
    wrong = 1'b0;
    chk("t3_ouch", int'(state), ST_OUCH);
    chk("t3_hp_self", int'(hp_self), 1);
    hold_then("t3_ouch", ST_OUCH, ST_READY);

    // 4: judge beats WRONG on the same cycle; then a DRAW
    begin_question();
    judg = 2'b01; wrong = 1'b1;
    cycle();
    judg = 2'b00; wrong = 1'b0;
    chk("t4_good", int'(state), ST_GOOD);
    hold_then("t4", ST_GOOD, ST_READY);
    begin_question();
    judg = 2'b11;
    cycle();
    judg = 2'b00;
    chk("t4_draw", int'(state), ST_DRAW);
    chk("t4_hp_self", int'(hp_self), 1);
    chk("t4_hp_opp", int'(hp_opp), 1);
    chk("t4_round", int'(round_cnt), 3);
    hold_then("t4_draw", ST_DRAW, ST_READY);

    // 5: asynchronous reset in the second cycle of a GOOD hold
    begin_question();
    judg = 2'b01;
    cycle();
    judg = 2'b00;
    cycle();
    chk("t5_pre", int'(state), ST_GOOD);
    async_reset();
    chk("t5_state", int'(state), ST_READY);
    chk("t5_hp_self", int'(hp_self), HP_INIT);
    chk("t5_hp_opp", int'(hp_opp), HP_INIT);
    chk("t5_round", int'(round_cnt), 0);
    chk("t5_busy", int'(hold_busy), 0);

    // 6: idle in QUESTION for the full answer time
    start_ok = 1'b1; que_ready = 1'b1;
    cycle();
    start_ok = 1'b0;
    repeat (TMO_CYC - 1) begin
      cycle();
      chk("t6_waiting", int'(state), ST_QUESTION);
    end
    cycle();
    chk("t6_state", int'(state), TMO_EN ? ST_OUCH : ST_QUESTION);
    chk("t6_hp_self", int'(hp_self), TMO_EN ? 1 : HP_INIT);

    // Randomized phase, compared against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      start_ok   = ($urandom_range(99, 0) < 70);
      que_ready  = ($urandom_range(99, 0) < 80);
      que_toggle = ($urandom_range(99, 0) < 20);
      wrong      = ($urandom_range(99, 0) < 15);
      judg       = ($urandom_range(99, 0) < 85) ? 2'b00 : 2'($urandom_range(3, 1));
      if ($urandom_range(499, 0) == 0) begin
        async_reset();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl_param.md
Name: game_ctrl_param

Overview:
- Parametrised second-generation round controller for the two-player factorization game.
- Sequences READY -> QUESTION/INPUT -> result display -> next round.
- Tracks both players' HP internally; the first generation took an external HP flag.
- Adds a configurable display-hold time, a wrong-answer penalty limit and a round counter. Sits between the input/judge modules and the display driver.

Parameters:
CLK_HZ, 50_000_000, clock frequency in Hz
HOLD_SEC, 1, result display hold time in seconds; HOLD_CYC = CLK_HZ*HOLD_SEC
HP_INIT, 3, starting HP per player (>=1)
HP_W, 2, HP register width; must hold HP_INIT
WRONG_MAX, 3, wrong answers per question before automatic OUCH (>=1)
ROUND_W, 4, round counter width
TIMEOUT_SEC, 10, answer time limit; used only with GAME_TIMEOUT_EN

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
START_OK  in  1  both players pressed start (level)
QUE_READY  in  1  question stored by input module (level)
QUE_TOGGLE  in  1  one-cycle pulse, switch between QUESTION and INPUT
JUDG  in  2  judge result: 00 none, 01 self correct, 10 opponent correct, 11 both correct
WRONG  in  1  one-cycle pulse, self answered incorrectly
STATE  out  4  READY=2, QUESTION=3, INPUT=4, DRAW=6, WRONG=7, GOOD=8, OUCH=9, WIN=10, LOSE=11
HP_SELF  out  HP_W  own HP
HP_OPP  out  HP_W  opponent HP
ROUND  out  ROUND_W  rounds played since last game start
HOLD_BUSY  out  1  high while in a hold state (WRONG/GOOD/OUCH/DRAW/WIN/LOSE)

Behaviour:
- Reset (async, immediate, any state): STATE=READY, HP_SELF=HP_OPP=HP_INIT, ROUND=0, HOLD_BUSY=0, wrong count=0, timers=0.
- Moore FSM, all outputs registered. Inputs sampled at edge t appear on STATE after edge t (1-cycle latency).
- READY:
  - START_OK && QUE_READY -> QUESTION, wrong count cleared. Otherwise stay.
- QUESTION:
  - JUDG=10 -> OUCH.
  - Else QUE_TOGGLE && QUE_READY -> INPUT.
  - Else stay.
- INPUT, priority order:
  1. JUDG=11 -> DRAW
  2. JUDG=01 -> GOOD
  3. JUDG=10 -> OUCH
  4. WRONG with wrong count = WRONG_MAX-1 -> OUCH, count cleared
  5. WRONG -> WRONG state, count +1
  6. QUE_TOGGLE -> QUESTION
  7. else stay
- Hold states: a hold counter clears on entry and increments each cycle. Expiry occurs at count HOLD_CYC-1, so each hold state lasts exactly HOLD_CYC cycles.
- WRONG on expiry -> INPUT.
- GOOD:
  - On entry: HP_OPP -1 (saturating at 0), ROUND +1.
  - On expiry: HP_OPP=0 -> WIN, else READY.
- OUCH:
  - On entry: HP_SELF -1 (saturating at 0), ROUND +1.
  - On expiry: HP_SELF=0 -> LOSE, else READY.
- DRAW:
  - On entry: ROUND +1, HP unchanged.
  - On expiry -> READY.
- WIN/LOSE on expiry -> READY, with HP_SELF=HP_OPP=HP_INIT and ROUND=0 on the same edge.
- ROUND saturates at all-ones.
- HOLD_BUSY=1 exactly when STATE is a hold state.
- JUDG and WRONG are ignored in hold states and READY.
- Undefined state encoding -> READY next cycle.

Optional Feature:
- Macro GAME_TIMEOUT_EN.
- Enabled:
  - An answer timer clears on the READY->QUESTION transition and counts while in QUESTION or INPUT.
  - It freezes in WRONG and resumes on return to INPUT.
  - Reaching CLK_HZ*TIMEOUT_SEC-1 forces OUCH, with the same HP/ROUND effects as OUCH.
  - Any JUDG-driven transition on the same cycle takes priority.
- Disabled: no answer timer; no time limit.

Test Plan:
Params CLK_HZ=4, HOLD_SEC=1 (HOLD_CYC=4), HP_INIT=2, WRONG_MAX=2 unless stated.
1. START_OK=1, QUE_READY=1 in READY -> STATE=3 next cycle; QUE_TOGGLE pulse -> STATE=4; JUDG=01 -> STATE=8, HP_OPP=1, ROUND=1, HOLD_BUSY=1 for 4 cycles, then STATE=2.
2. Two GOOD rounds -> second GOOD expiry gives STATE=10 for 4 cycles, then STATE=2, HP_SELF=HP_OPP=2, ROUND=0.
3. In INPUT, WRONG pulse -> STATE=7 for 4 cycles, back to 4; second WRONG -> STATE=9, HP_SELF=1.
4. In INPUT, JUDG=01 and WRONG on the same cycle -> STATE=8 (judge wins); JUDG=11 -> STATE=6, HP unchanged, ROUND+1.
5. RST pulse mid-GOOD (cycle 2 of hold) -> STATE=2, HP=2/2, ROUND=0, HOLD_BUSY=0 immediately, without waiting for a clock edge.
6. With GAME_TIMEOUT_EN, TIMEOUT_SEC=2: enter QUESTION, no input for 8 cycles -> STATE=9 at cycle 8, HP_SELF=1; without the macro -> remains STATE=3.
